// File: rtl/eth_decap.sv
// Receive side of the TLP capture tunnel: validates the 48-byte Eth/IPv4/UDP/TCAP header,
// strips it, and forwards the payload beats to the TLP FIFO in the 74-bit encap word format.
module eth_decap #(
  parameter logic [47:0] eth_addr  = 48'h00_11_22_33_44_55,
  parameter logic [15:0] udp_dport = 16'h3776,
  parameter logic [1:0]  tcap_ver  = 2'b01
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [39:0] tcap_ts,
  output logic        tcap_dir,
  output logic [31:0] pkt_ok_cnt,
  output logic [31:0] pkt_drop_cnt
);

  typedef enum logic [1:0] {
    RX_HDR  = 2'd0,
    RX_DATA = 2'd1,
    RX_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [47:0] h_dest;
    logic [47:0] h_src;
    logic [15:0] h_proto;
  } eth_hdr_t;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ip_hdr_t;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dest;
    logic [15:0] len;
    logic [15:0] checksum;
  } udp_hdr_t;

  typedef struct packed {
    logic [1:0]  ver;
    logic        dir;
    logic [4:0]  rsvd;
    logic [39:0] ts;
  } tcap_hdr_t;

  typedef struct packed {
    eth_hdr_t  eth;
    ip_hdr_t   ip;
    udp_hdr_t  udp;
    tcap_hdr_t tcap;
  } hdr_t;

  // raw[5] holds the first wire beat so the struct fields read in network order
  typedef union packed {
    logic [5:0][63:0] raw;
    hdr_t             h;
  } packet_t;

  function automatic logic [63:0] endian_conv64(input logic [63:0] d);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) begin
      r[63-8*j -: 8] = d[8*j +: 8];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  packet_t     hdr_q, hdr_d;
  logic [31:0] ok_cnt_q, ok_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [39:0] ts_q, ts_d;
  logic        dir_q, dir_d;

  logic        ready_c;
  logic        accept;
  logic [2:0]  hdr_idx;
  packet_t     hdr_cat;
  logic        hdr_match;

  // Header image including the beat currently on the bus, so beat 5 is judged on its own edge
  always_comb begin
    hdr_idx              = 3'd5 - beat_cnt_q;
    hdr_cat              = hdr_q;
    hdr_cat.raw[hdr_idx] = endian_conv64(s_axis_tdata);
    hdr_match = ((hdr_cat.h.eth.h_dest == eth_addr) || (hdr_cat.h.eth.h_dest == '1))
             && (hdr_cat.h.eth.h_proto == 16'h0800)
             && (hdr_cat.h.ip.version == 4'd4)
             && (hdr_cat.h.ip.ihl == 4'd5)
             && (hdr_cat.h.ip.protocol == 8'd17)
             && (hdr_cat.h.udp.dest == udp_dport)
             && (hdr_cat.h.tcap.ver == tcap_ver);
  end

  assign accept = s_axis_tvalid && ready_c;

  // NOTE: every signal written here gets a default first, otherwise the missing paths infer latches.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    hdr_d      = hdr_q;
    ok_cnt_d   = ok_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ts_d       = ts_q;
    dir_d      = dir_q;
    ready_c    = 1'b0;
    wr_en      = 1'b0;

    unique case (state_q)
      RX_HDR: begin
        ready_c = 1'b1;
        if (accept) begin
          hdr_d = hdr_cat;
          if (s_axis_tlast) begin
            // Runt, or a frame that ends right at the header: never forwarded
            drop_cnt_d = drop_cnt_q + 32'd1;
            beat_cnt_d = 3'd0;
          end else if (beat_cnt_q == 3'd5) begin
            beat_cnt_d = 3'd0;
            if (hdr_match) begin
              state_d = RX_DATA;
              ts_d    = hdr_cat.h.tcap.ts;
              dir_d   = hdr_cat.h.tcap.dir;
            end else begin
              state_d = RX_DROP;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end

      RX_DATA: begin
        ready_c = !full;
        wr_en   = s_axis_tvalid && !full;
        if (wr_en && s_axis_tlast) begin
          ok_cnt_d   = ok_cnt_q + 32'd1;
          beat_cnt_d = 3'd0;
          state_d    = RX_HDR;
        end
      end

      RX_DROP: begin
        ready_c = 1'b1;
        if (accept && s_axis_tlast) begin
          drop_cnt_d = drop_cnt_q + 32'd1;
          beat_cnt_d = 3'd0;
          state_d    = RX_HDR;
        end
      end

      default: begin
        state_d    = RX_HDR;
        beat_cnt_d = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= RX_HDR;
      beat_cnt_q <= 3'd0;
      ok_cnt_q   <= 32'd0;
      drop_cnt_q <= 32'd0;
      ts_q       <= 40'd0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      ok_cnt_q   <= ok_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ts_q       <= ts_d;
      dir_q      <= dir_d;
    end
  end

  // NOTE: the header store is pure datapath, fully rewritten before it is judged, so it has no reset.
  always_ff @(posedge clk156) begin
    hdr_q <= hdr_d;
  end

  assign s_axis_tready = ready_c && !sys_rst;
  assign din           = {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser};
  assign tcap_ts       = ts_q;
  assign tcap_dir      = dir_q;
  assign pkt_ok_cnt    = ok_cnt_q;
  assign pkt_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_eth_decap.sv
// Directed bench for eth_decap: builds TCAP frames byte by byte and checks FIFO writes,
// backpressure, counters and the latched timestamp against hand-derived values.
`timescale 1ns/100ps
module tb_eth_decap;

  localparam logic [47:0] ETH_ADDR = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST    = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [39:0] TS_DEF   = 40'haa_aaaa_aaaa;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic        wr_en;
  logic [73:0] din;
  logic        full;
  logic [39:0] tcap_ts;
  logic        tcap_dir;
  logic [31:0] pkt_ok_cnt;
  logic [31:0] pkt_drop_cnt;

  eth_decap dut (
    .clk156        (clk156),
    .sys_rst       (sys_rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .wr_en         (wr_en),
    .din           (din),
    .full          (full),
    .tcap_ts       (tcap_ts),
    .tcap_dir      (tcap_dir),
    .pkt_ok_cnt    (pkt_ok_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt)
  );

  always #3.2 clk156 = ~clk156;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [73:0] wq[$];
  int          stall_cnt = 0;
  int          wr_full_viol = 0;
  logic [7:0]  hb[48];
  int          exp_ok = 0;
  int          exp_drop = 0;

  // Inputs change on the falling edge; the write log is sampled 1ns later, well before the rising edge
  always @(negedge clk156) begin
    #1;
    if (wr_en) begin
      wq.push_back(din);
      if (full) wr_full_viol++;
    end
    if (s_axis_tvalid && !s_axis_tready && !sys_rst) stall_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int off, input int n, input logic [63:0] v);
    for (int b = 0; b < n; b++) hb[off+b] = v[8*(n-1-b) +: 8];
  endtask

  task automatic build_hdr(input logic [47:0] dest, input logic [15:0] proto,
                           input logic [15:0] dport, input logic [39:0] ts, input logic dir);
    put(0, 6, {16'h0, dest});
    put(6, 6, 64'h0000_0200_0000_0001);
    put(12, 2, {48'h0, proto});
    put(14, 2, 64'h4500);               // version 4, ihl 5, tos 0
    put(16, 2, 64'h0042);               // total length 66
    put(18, 4, 64'h0000_4000);          // id 0, DF
    put(22, 2, 64'h4011);               // ttl 64, protocol 17
    put(24, 2, 64'h0);
    put(26, 4, 64'hc0a8_0001);
    put(30, 4, 64'hc0a8_0002);
    put(34, 2, 64'h3776);
    put(36, 2, {48'h0, dport});
    put(38, 2, 64'h002e);
    put(40, 2, 64'h0);
    hb[42] = {2'b01, dir, 5'b0};
    put(43, 5, {24'h0, ts});
  endtask

  function automatic logic [63:0] hdr_beat(input int i);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = hb[8*i+j];
    return d;
  endfunction

  function automatic logic [73:0] exp_din(input logic [63:0] seed, input int k, input int n,
                                          input logic user);
    logic last;
    last = (k == n - 1);
    return {8'hFF, seed + 64'(k), last, last & user};
  endfunction

  task automatic wait_accept();
    logic acc;
    int   guard;
    guard = 0;
    do begin
      #1;
      acc = s_axis_tready;
      @(posedge clk156);
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic u, input int stall);
    @(negedge clk156);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    if (stall > 0) begin
      full = 1'b1;
      repeat (stall) @(negedge clk156);
      full = 1'b0;
    end
    wait_accept();
  endtask

  task automatic idle(input int n);
    @(negedge clk156);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (n) @(negedge clk156);
  endtask

  task automatic send_hdr(input int nbeats, input logic last_on_final);
    for (int i = 0; i < nbeats; i++)
      send_beat(hdr_beat(i), last_on_final && (i == nbeats - 1), 1'b0, 0);
  endtask

  task automatic send_frame(input logic [63:0] seed, input int n_pl, input int stall_idx,
                            input logic user_last);
    send_hdr(6, 1'b0);
    for (int k = 0; k < n_pl; k++)
      send_beat(seed + 64'(k), k == n_pl - 1, user_last && (k == n_pl - 1),
                (k == stall_idx) ? 3 : 0);
  endtask

  task automatic check_writes(input string tag, input logic [63:0] seed, input int n,
                              input logic user);
    check({tag, "_nwr"}, wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++)
      check($sformatf("%s_din%0d", tag, k), wq[k], exp_din(seed, k, n, user));
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_ok"}, pkt_ok_cnt, exp_ok);
    check({tag, "_drop"}, pkt_drop_cnt, exp_drop);
  endtask

  initial begin
    sys_rst       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    full          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk156);
    #2;
    check("rst_tready", s_axis_tready, 0);
    check("rst_wr_en", wr_en, 0);
    check_cnts("rst");
    check("rst_ts", tcap_ts, 0);
    check("rst_dir", tcap_dir, 0);
    @(negedge clk156);
    sys_rst = 1'b0;
    idle(2);

    // 1: valid unicast frame, four payload beats
    build_hdr(ETH_ADDR, 16'h0800, 16'h3776, TS_DEF, 1'b1);
    wq.delete();
    send_frame(64'h1111_0000_0000_0000, 4, -1, 1'b0);
    idle(2);
    exp_ok++;
    check_writes("t1", 64'h1111_0000_0000_0000, 4, 1'b0);
    check_cnts("t1");
    check("t1_ts", tcap_ts, TS_DEF);
    check("t1_dir", tcap_dir, 1);
    check("t1_idle_wr_en", wr_en, 0);

    // 2: wrong UDP port, whole frame consumed without stalls
    build_hdr(ETH_ADDR, 16'h0800, 16'h1234, TS_DEF, 1'b1);
    wq.delete();
    stall_cnt = 0;
    send_frame(64'h2222_0000_0000_0000, 4, -1, 1'b0);
    idle(2);
    exp_drop++;
    check("t2_nwr", wq.size(), 0);
    check("t2_stalls", stall_cnt, 0);
    check_cnts("t2");

    // 3: FIFO full for three cycles on payload beat 2
    build_hdr(ETH_ADDR, 16'h0800, 16'h3776, TS_DEF, 1'b1);
    wq.delete();
    stall_cnt = 0;
    send_frame(64'h3333_0000_0000_0000, 4, 1, 1'b0);
    idle(2);
    exp_ok++;
    check("t3_stalls", stall_cnt, 3);
    check_writes("t3", 64'h3333_0000_0000_0000, 4, 1'b0);
    check_cnts("t3");

    // 4: runt ending on beat 2, then a valid frame back-to-back
    wq.delete();
    send_hdr(3, 1'b1);
    send_frame(64'h4444_0000_0000_0000, 4, -1, 1'b0);
    idle(2);
    exp_drop++;
    exp_ok++;
    check_writes("t4", 64'h4444_0000_0000_0000, 4, 1'b0);
    check_cnts("t4");

    // 5: broadcast with IPv6 ethertype is dropped; broadcast valid frame accepted, tuser forwarded
    build_hdr(BCAST, 16'h86DD, 16'h3776, TS_DEF, 1'b1);
    wq.delete();
    send_frame(64'h5555_0000_0000_0000, 4, -1, 1'b0);
    idle(2);
    exp_drop++;
    check("t5a_nwr", wq.size(), 0);
    check_cnts("t5a");
    build_hdr(BCAST, 16'h0800, 16'h3776, 40'h01_2345_6789, 1'b0);
    wq.delete();
    send_frame(64'h5566_0000_0000_0000, 4, -1, 1'b1);
    idle(2);
    exp_ok++;
    check_writes("t5b", 64'h5566_0000_0000_0000, 4, 1'b1);
    check_cnts("t5b");
    check("t5b_ts", tcap_ts, 40'h01_2345_6789);
    check("t5b_dir", tcap_dir, 0);

    // 6: reset during payload beat 1, trailing beats become one runt drop
    build_hdr(ETH_ADDR, 16'h0800, 16'h3776, TS_DEF, 1'b1);
    send_hdr(6, 1'b0);
    send_beat(64'h6666_0000_0000_0000, 1'b0, 1'b0, 0);
    @(negedge clk156);
    s_axis_tdata = 64'h6666_0000_0000_0001;
    sys_rst      = 1'b1;
    #2;
    exp_ok   = 0;
    exp_drop = 0;
    check("t6_rst_wr_en", wr_en, 0);
    check("t6_rst_tready", s_axis_tready, 0);
    check_cnts("t6_rst");
    check("t6_rst_ts", tcap_ts, 0);
    @(negedge clk156);
    sys_rst = 1'b0;
    wq.delete();
    wait_accept();
    send_beat(64'h6666_0000_0000_0002, 1'b0, 1'b0, 0);
    send_beat(64'h6666_0000_0000_0003, 1'b1, 1'b0, 0);
    idle(2);
    exp_drop++;
    check("t6_tail_nwr", wq.size(), 0);
    check_cnts("t6_tail");
    wq.delete();
    send_frame(64'h7777_0000_0000_0000, 4, -1, 1'b0);
    idle(2);
    exp_ok++;
    check_writes("t6", 64'h7777_0000_0000_0000, 4, 1'b0);
    check_cnts("t6");
    check("t6_ts", tcap_ts, TS_DEF);

    check("wr_while_full", wr_full_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
